// File: rtl/udp_stream_packer.sv
// Packs a raw byte stream into fixed-length UDP payloads in the UDP TX RAM.
// Partial payloads are flushed on input idle timeout or enable drop. A watchdog guards the send.
module udp_stream_packer #(
    parameter int unsigned PKT_LEN       = 1024,
    parameter int unsigned FLUSH_TIMEOUT = 125000,
    parameter int unsigned TX_TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic        i_udp_ram_data_req,
    input  logic        i_almost_full,
    output logic [7:0]  o_ram_wr_data,
    output logic        o_ram_wr_en,
    output logic        o_udp_tx_req,
    output logic [15:0] o_udp_send_data_length,
    input  logic        i_udp_tx_end,
    output logic [31:0] o_pkt_count,
    output logic        o_tx_timeout_err
);

    localparam logic [15:0] PktLen    = 16'(PKT_LEN);
    localparam logic [31:0] IdleLimit = 32'(FLUSH_TIMEOUT - 1);
    localparam logic [31:0] WdLimit   = 32'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StLast,
        StReq,
        StWaitEnd
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_byte_cnt;
    logic [31:0] r_idle_cnt;
    logic [31:0] r_wd_cnt;
    logic        r_wr_en;
    logic [7:0]  r_wr_data;
    logic [15:0] r_len;
    logic [31:0] r_pkt_cnt;
    logic        r_err;

    logic w_hs;
    logic w_last_byte;
    logic w_has_data;
    logic w_flush;
    logic w_tx_ok;
    logic w_tx_to;

    assign o_s_ready   = (r_state == StFill) & ~i_almost_full & (r_byte_cnt < PktLen);
    assign w_hs        = i_s_valid & o_s_ready;
    assign w_last_byte = w_hs & (r_byte_cnt == PktLen - 16'd1);
    assign w_has_data  = (r_byte_cnt != 16'd0);
    // A handshake in the same cycle means the input is not idle, so no flush.
    assign w_flush     = ~w_hs & w_has_data & (r_idle_cnt == IdleLimit);
    assign w_tx_ok     = (r_state == StWaitEnd) & i_udp_tx_end;
    assign w_tx_to     = (r_state == StWaitEnd) & ~i_udp_tx_end & (r_wd_cnt == WdLimit);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_enable && i_udp_ram_data_req) begin
                    w_state_nxt = StFill;
                end
            end
            StFill: begin
                if (w_last_byte) begin
                    w_state_nxt = StLast;
                end else if (!i_enable) begin
                    w_state_nxt = (w_has_data || w_hs) ? StReq : StIdle;
                end else if (w_flush) begin
                    w_state_nxt = StReq;
                end
            end
            StLast:    w_state_nxt = StReq;
            StReq:     w_state_nxt = StWaitEnd;
            StWaitEnd: begin
                if (w_tx_ok || w_tx_to) begin
                    w_state_nxt = StIdle;
                end
            end
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= 16'd0;
            r_idle_cnt <= 32'd0;
            r_wd_cnt   <= 32'd0;
        end else begin
            if (r_state == StIdle && w_state_nxt == StFill) begin
                r_byte_cnt <= 16'd0;
            end else if (w_hs) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end

            // Backpressure with data waiting is not idleness.
            if (r_state != StFill || w_hs || !w_has_data) begin
                r_idle_cnt <= 32'd0;
            end else if (!(i_almost_full && i_s_valid)) begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end

            if (r_state != StWaitEnd) begin
                r_wd_cnt <= 32'd0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= 8'd0;
            r_len     <= 16'd0;
            r_pkt_cnt <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_hs;
            if (w_hs) begin
                r_wr_data <= i_s_data;
            end
            // Latch the final count as REQ is entered so it is valid alongside udp_tx_req.
            if (w_state_nxt == StReq && r_state != StReq) begin
                r_len <= r_byte_cnt + {15'd0, w_hs};
            end
            if (w_tx_ok) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_tx_to) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ram_wr_en            = r_wr_en;
    assign o_ram_wr_data          = r_wr_data;
    assign o_udp_tx_req           = (r_state == StReq);
    assign o_udp_send_data_length = r_len;
    assign o_pkt_count            = r_pkt_cnt;
    assign o_tx_timeout_err       = r_err;

endmodule
